uart_bist_core: RTL and testbench



---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_rx_fifo.sv | 48 ++++
 rtl/uart_bist_core.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_bist_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART/BIST core.
// State encodings, error bit positions, BIST patterns, parity.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_CTS,
        TX_SHIFT
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        BI_IDLE,
        BI_SEND,
        BI_WAIT_RX,
        BI_DONE
    } bist_state_t;

    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAME   = 1;
    localparam int ERR_OVERRUN = 2;

    localparam logic [7:0] BIST_PAT [4] = '{8'h55, 8'hAA, 8'h00, 8'hFF};

    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

    function automatic logic [7:0] bist_pattern(input logic [1:0] idx);
        return BIST_PAT[idx];
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: circular buffer, extra pointer bit for full/empty.
// Head is read combinationally (first-word fall-through).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = r_mem[r_rd[AW-1:0]];

    // Storage and pointer update; push into a full FIFO only with a pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr[AW-1:0]] <= i_data;
                r_wr                <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
        end
    end

endmodule

// File: rtl/uart_bist_core.sv
// UART with TX/RX, receive FIFO, RTS/CTS and a loopback BIST engine.
// Frame: start, data MSB first, even parity, stop bits.
module uart_bist_core
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 4,
    parameter int BAUD_RATE   = 1,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int BIST_LEN    = 4
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic                 Rx,
    output logic                 Tx,
    input  logic                 CTS,
    output logic                 RTS,
    input  logic [DATA_BITS-1:0] Wr_Data,
    input  logic                 Wr_En,
    output logic                 Tx_Busy,
    input  logic                 Rd_En,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Data_Rdy,
    output logic                 FIFO_Empty,
    output logic [2:0]           Rx_Error,
    input  logic                 BIST_Start,
    output logic                 BIST_Busy,
    output logic                 BIST_Error
);
    localparam int DIV  = SYSCLK_RATE / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int NB   = DATA_BITS + 2 + STOP_BITS;
    localparam int CW   = $clog2(DIV);
    localparam int BW   = $clog2(NB + 1);
    localparam int IW   = $clog2(BIST_LEN + 1);

    tx_state_t             r_tx_state;
    logic [NB-1:0]         r_tx_frame;
    logic [CW-1:0]         r_tx_cnt;
    logic [BW-1:0]         r_tx_bit;
    logic                  r_tx;

    rx_state_t             r_rx_state;
    logic                  r_s1, r_s2, r_rx_prev;
    logic [CW-1:0]         r_rx_cnt;
    logic [BW-1:0]         r_rx_bit;
    logic [DATA_BITS-1:0]  r_rx_sh;
    logic                  r_rx_par;
    logic                  r_rx_stop_ok;
    logic [2:0]            r_rx_err;

    bist_state_t           r_bstate;
    logic [IW-1:0]         r_bidx;
    logic                  r_bist_busy;
    logic                  r_bist_err;
    logic                  r_rts;

    logic                  w_rx_src;
    logic                  w_tx_tick, w_rx_tick;
    logic                  w_bist_accept, w_tx_load;
    logic [DATA_BITS-1:0]  w_bist_pat, w_tx_data;
    logic                  w_rx_done, w_par_err, w_frm_err;
    logic                  w_push_req, w_ovr, w_fifo_push;
    logic                  w_empty, w_full, w_bist_miss;

    assign w_tx_tick     = (r_tx_cnt == CW'(DIV - 1));
    assign w_rx_tick     = (r_rx_cnt == CW'(DIV - 1));
    assign w_bist_accept = BIST_Start && r_bstate == BI_IDLE &&
                           r_tx_state == TX_IDLE && r_rx_state == RX_IDLE;
    assign w_bist_pat    = DATA_BITS'(bist_pattern(2'(r_bidx)));
    assign w_tx_load     = (r_tx_state == TX_IDLE) &&
                           ((Wr_En && !r_bist_busy && !w_bist_accept) ||
                            r_bstate == BI_SEND);
    assign w_tx_data     = r_bist_busy ? w_bist_pat : Wr_Data;
    assign w_rx_src      = r_bist_busy ? r_tx : r_s2;
    assign w_rx_done     = r_rx_state == RX_STOP && w_rx_tick &&
                           r_rx_bit == BW'(STOP_BITS - 1);
    assign w_par_err     = r_rx_par ^ even_parity(32'(r_rx_sh));
    assign w_frm_err     = ~(r_rx_stop_ok & w_rx_src);
    assign w_push_req    = w_rx_done & ~w_par_err & ~w_frm_err & ~r_bist_busy;
    assign w_ovr         = w_push_req & w_full & ~Rd_En;
    assign w_fifo_push   = w_push_req & ~w_ovr;
    assign w_bist_miss   = (r_rx_sh != w_bist_pat) | w_par_err | w_frm_err;

    assign Tx         = r_bist_busy ? 1'b1 : r_tx;
    assign Tx_Busy    = (r_tx_state != TX_IDLE);
    assign RTS        = r_rts;
    assign FIFO_Empty = w_empty;
    assign Data_Rdy   = ~w_empty;
    assign Rx_Error   = r_rx_err;
    assign BIST_Busy  = r_bist_busy;
    assign BIST_Error = r_bist_err;

    // Transmitter: latch frame, wait for CTS, shift each bit for DIV cycles.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_frame <= '1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx       <= 1'b1;
        end else begin
            unique case (r_tx_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_tx_load) begin
                        r_tx_frame <= {1'b0, w_tx_data,
                                       even_parity(32'(w_tx_data)),
                                       {STOP_BITS{1'b1}}};
                        r_tx_state <= TX_WAIT_CTS;
                    end
                end
                TX_WAIT_CTS: begin
                    if (CTS || r_bist_busy) begin
                        r_tx       <= r_tx_frame[NB-1];
                        r_tx_frame <= {r_tx_frame[NB-2:0], 1'b1};
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == BW'(NB - 1)) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx       <= r_tx_frame[NB-1];
                            r_tx_frame <= {r_tx_frame[NB-2:0], 1'b1};
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Receiver: synchronise, detect start edge, sample mid-bit, report status.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            r_s1         <= 1'b1;
            r_s2         <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_sh      <= '0;
            r_rx_par     <= 1'b0;
            r_rx_stop_ok <= 1'b1;
            r_rx_err     <= '0;
        end else begin
            r_s1      <= Rx;
            r_s2      <= r_s1;
            r_rx_prev <= w_rx_src;
            unique case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev && !w_rx_src) r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (r_rx_cnt == CW'(HALF - 1)) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= w_rx_src ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rx_sh[DATA_BITS-2:0], w_rx_src};
                        if (r_rx_bit == BW'(DATA_BITS - 1)) begin
                            r_rx_bit   <= '0;
                            r_rx_state <= RX_PARITY;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (w_rx_tick) begin
                        r_rx_cnt     <= '0;
                        r_rx_bit     <= '0;
                        r_rx_par     <= w_rx_src;
                        r_rx_stop_ok <= 1'b1;
                        r_rx_state   <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_cnt <= '0;
                        if (w_rx_done) begin
                            r_rx_err[ERR_PARITY]  <= w_par_err;
                            r_rx_err[ERR_FRAME]   <= w_frm_err;
                            r_rx_err[ERR_OVERRUN] <= w_ovr;
                            r_rx_state            <= RX_IDLE;
                        end else begin
                            r_rx_stop_ok <= r_rx_stop_ok & w_rx_src;
                            r_rx_bit     <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // BIST sequencer: send each pattern via loopback and compare on receipt.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            r_bstate    <= BI_IDLE;
            r_bidx      <= '0;
            r_bist_busy <= 1'b0;
            r_bist_err  <= 1'b0;
        end else begin
            unique case (r_bstate)
                BI_IDLE: begin
                    if (w_bist_accept) begin
                        r_bist_busy <= 1'b1;
                        r_bist_err  <= 1'b0;
                        r_bidx      <= '0;
                        r_bstate    <= BI_SEND;
                    end
                end
                BI_SEND: begin
                    if (r_tx_state == TX_IDLE) r_bstate <= BI_WAIT_RX;
                end
                BI_WAIT_RX: begin
                    if (w_rx_done) begin
                        if (w_bist_miss) r_bist_err <= 1'b1;
                        if (r_bidx == IW'(BIST_LEN - 1)) begin
                            r_bist_busy <= 1'b0;
                            r_bstate    <= BI_DONE;
                        end else begin
                            r_bidx   <= r_bidx + 1'b1;
                            r_bstate <= BI_SEND;
                        end
                    end
                end
                BI_DONE: r_bstate <= BI_IDLE;
                default: r_bstate <= BI_IDLE;
            endcase
        end
    end

    // Flow control: request data only with FIFO room and BIST idle.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) r_rts <= 1'b0;
        else      r_rts <= ~w_full & ~r_bist_busy;
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (SysClk),
        .i_rst_n (Rst),
        .i_push  (w_fifo_push),
        .i_data  (r_rx_sh),
        .i_pop   (Rd_En),
        .o_data  (Rx_Data),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

endmodule

// File: tb/tb_uart_bist_core.sv
// Directed bench for uart_bist_core with TX-bit and RX-byte scoreboards.
// DIV=4, 8 data bits, even parity, 2 stop bits.
module tb_uart_bist_core;

    logic       clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx = 1'b1;
    logic       Tx;
    logic       CTS = 1'b0;
    logic       RTS;
    logic [7:0] Wr_Data = 8'h00;
    logic       Wr_En = 1'b0;
    logic       Tx_Busy;
    logic       Rd_En = 1'b0;
    logic [7:0] Rx_Data;
    logic       Data_Rdy;
    logic       FIFO_Empty;
    logic [2:0] Rx_Error;
    logic       BIST_Start = 1'b0;
    logic       BIST_Busy;
    logic       BIST_Error;

    int checks = 0;
    int failures = 0;

    logic       txq [$];
    logic [7:0] rxq [$];

    always #5 clk = ~clk;

    uart_bist_core dut (
        .SysClk     (clk),
        .Rst        (Rst),
        .Rx         (Rx),
        .Tx         (Tx),
        .CTS        (CTS),
        .RTS        (RTS),
        .Wr_Data    (Wr_Data),
        .Wr_En      (Wr_En),
        .Tx_Busy    (Tx_Busy),
        .Rd_En      (Rd_En),
        .Rx_Data    (Rx_Data),
        .Data_Rdy   (Data_Rdy),
        .FIFO_Empty (FIFO_Empty),
        .Rx_Error   (Rx_Error),
        .BIST_Start (BIST_Start),
        .BIST_Busy  (BIST_Busy),
        .BIST_Error (BIST_Error)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one serial frame on Rx, optional bad parity / bad first stop.
    task automatic send_rx(input logic [7:0] d, input logic par_flip,
                           input logic stop0);
        logic [11:0] f;
        f = {1'b0, d, (^d) ^ par_flip, stop0, 1'b1};
        for (int i = 11; i >= 0; i--) begin
            Rx = f[i];
            cyc(4);
        end
        Rx = 1'b1;
        cyc(8);
    endtask

    // Read the FIFO head against the scoreboard, then pop it.
    task automatic rd_check();
        logic [7:0] e;
        e = rxq.pop_front();
        check("rx_data", Rx_Data, e);
        Rd_En = 1'b1;
        cyc(1);
        Rd_En = 1'b0;
    endtask

    // Send one byte and check every serial bit at both ends of its slot.
    task automatic tx_frame(input logic [7:0] d, input logic hold_cts);
        logic [11:0] f;
        int lows;
        int found;
        logic e;
        f = {1'b0, d, ^d, 2'b11};
        for (int i = 11; i >= 0; i--) txq.push_back(f[i]);
        Wr_Data = d;
        Wr_En = 1'b1;
        cyc(1);
        Wr_En = 1'b0;
        check("tx_busy_set", Tx_Busy, 1);
        if (hold_cts) begin
            lows = 0;
            for (int i = 0; i < 10; i++) begin
                Wr_Data = ~d;
                Wr_En = (i == 3);
                cyc(1);
                if (Tx !== 1'b1) lows++;
            end
            Wr_En = 1'b0;
            check("tx_cts_hold", lows, 0);
            CTS = 1'b1;
        end
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (Tx === 1'b0) found = 1;
            else cyc(1);
        end
        check("tx_start_seen", found, 1);
        if (found == 1) begin
            for (int b = 0; b < 12; b++) begin
                e = txq.pop_front();
                check("tx_bit_first", Tx, e);
                cyc(3);
                check("tx_bit_last", Tx, e);
                cyc(1);
            end
            check("tx_busy_clear", Tx_Busy, 0);
            check("tx_idle_high", Tx, 1);
        end
        txq.delete();
    endtask

    // Run one BIST, optionally corrupting the loopback path.
    task automatic run_bist(input logic corrupt, output int busy_cyc,
                            output int lows, output int rts_hi);
        busy_cyc = 0;
        lows = 0;
        rts_hi = 0;
        BIST_Start = 1'b1;
        cyc(1);
        BIST_Start = 1'b0;
        check("bist_busy_set", BIST_Busy, 1);
        check("bist_err_clr", BIST_Error, 0);
        cyc(1);
        for (int i = 0; i < 600 && BIST_Busy === 1'b1; i++) begin
            busy_cyc++;
            if (Tx !== 1'b1) lows++;
            if (RTS !== 1'b0) rts_hi++;
            if (corrupt && i == 10) force dut.w_rx_src = 1'b1;
            if (corrupt && i == 22) release dut.w_rx_src;
            cyc(1);
        end
        check("bist_done", BIST_Busy, 0);
    endtask

    initial begin
        int bc, lo, rh;

        // Reset state
        cyc(3);
        check("rst_tx", Tx, 1);
        check("rst_tx_busy", Tx_Busy, 0);
        check("rst_rts", RTS, 0);
        check("rst_empty", FIFO_Empty, 1);
        check("rst_rdy", Data_Rdy, 0);
        check("rst_rx_data", Rx_Data, 0);
        check("rst_rx_err", Rx_Error, 0);
        check("rst_bist_busy", BIST_Busy, 0);
        check("rst_bist_err", BIST_Error, 0);
        Rst = 1'b1;
        cyc(1);
        check("rts_after_rst", RTS, 1);
        cyc(4);

        // Transmit with CTS high, then held off by CTS low
        CTS = 1'b1;
        tx_frame(8'hAB, 1'b0);
        cyc(3);
        CTS = 1'b0;
        tx_frame(8'h3C, 1'b1);
        cyc(3);

        // Single good receive frame
        rxq.push_back(8'hAA);
        send_rx(8'hAA, 1'b0, 1'b1);
        check("rx_not_empty", FIFO_Empty, 0);
        check("rx_rdy", Data_Rdy, 1);
        check("rx_err_ok", Rx_Error, 0);
        rd_check();
        check("rx_empty_again", FIFO_Empty, 1);

        // Fill the FIFO, then overrun
        for (int i = 0; i < 8; i++) begin
            rxq.push_back(8'(i));
            send_rx(8'(i), 1'b0, 1'b1);
        end
        check("full_rts_low", RTS, 0);
        check("full_err_ok", Rx_Error, 0);
        send_rx(8'h08, 1'b0, 1'b1);
        check("overrun_err", Rx_Error, 3'b100);
        for (int i = 0; i < 8; i++) rd_check();
        check("drain_empty", FIFO_Empty, 1);
        cyc(1);
        check("drain_rts", RTS, 1);

        // Parity and framing errors are not stored
        send_rx(8'h01, 1'b1, 1'b1);
        check("parity_err", Rx_Error, 3'b001);
        check("parity_drop", FIFO_Empty, 1);
        send_rx(8'h02, 1'b0, 1'b0);
        check("frame_err", Rx_Error, 3'b010);
        check("frame_drop", FIFO_Empty, 1);
        rxq.push_back(8'h3C);
        send_rx(8'h3C, 1'b0, 1'b1);
        check("recover_err", Rx_Error, 0);
        check("recover_data", Rx_Data, rxq[0]);

        // Clean BIST
        run_bist(1'b0, bc, lo, rh);
        check("bist_len", bc >= 192, 1);
        check("bist_tx_quiet", lo, 0);
        check("bist_rts_low", rh, 0);
        check("bist_pass", BIST_Error, 0);
        check("bist_fifo_kept", FIFO_Empty, 0);
        check("bist_fifo_data", Rx_Data, rxq[0]);
        cyc(4);

        // BIST with corrupted loopback
        run_bist(1'b1, bc, lo, rh);
        check("bist_fail", BIST_Error, 1);
        check("bist2_fifo_data", Rx_Data, rxq[0]);
        cyc(4);

        // Reset in the middle of a transmit frame
        CTS = 1'b1;
        Wr_Data = 8'h5A;
        Wr_En = 1'b1;
        cyc(1);
        Wr_En = 1'b0;
        cyc(20);
        check("mid_busy", Tx_Busy, 1);
        Rst = 1'b0;
        #1;
        check("mid_rst_tx", Tx, 1);
        check("mid_rst_busy", Tx_Busy, 0);
        check("mid_rst_empty", FIFO_Empty, 1);
        check("mid_rst_rts", RTS, 0);
        check("mid_rst_berr", BIST_Error, 0);
        rxq.delete();
        cyc(2);
        Rst = 1'b1;
        cyc(1);
        check("mid_rel_rts", RTS, 1);
        check("mid_rel_tx", Tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
